// File: rtl/lps_pkg.sv
// Shared types, mode encodings and seed helper for the LED pattern sequencer.
package lps_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_ROTL = 2'd0;
    localparam logic [1:0] MODE_ROTR = 2'd1;
    localparam logic [1:0] MODE_PING = 2'd2;
    localparam logic [1:0] MODE_FILL = 2'd3;

    // First LED pattern shown for a mode; rotate-right starts from the MSB.
    function automatic logic [31:0] seed(input logic [1:0] mode, input int w);
        logic [31:0] v;
        if (mode == MODE_ROTR) begin
            v = 32'd1 << (w - 32'sd1);
        end else begin
            v = 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchronises an asynchronous button level and emits a registered one-cycle
// pulse on each rising edge.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    // Synchroniser chain, previous-level register and registered edge pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= {SYNC_STAGES{1'b0}};
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED chaser: four animated patterns at a selectable speed, with run/pause/clear
// control from two asynchronous buttons.
module led_pattern_sequencer
    import lps_pkg::*;
#(
    parameter int LED_W       = 8,
    parameter int TICK_DIV    = 100_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_start,
    input  logic             i_btn_stop,
    input  logic [1:0]       i_mode,
    input  logic [1:0]       i_speed,
    output logic [LED_W-1:0] o_led,
    output logic             o_running
);

    localparam logic [LED_W-1:0] LED_ZERO = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TICK_DIV_C = CNT_W'(TICK_DIV);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             w_start_p;
    logic             w_stop_p;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_running;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_led_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    dir_e             r_dir;
    dir_e             w_dir_nxt;
    logic [1:0]       r_mode_q;
    logic [1:0]       w_mode_q_nxt;

    logic [CNT_W-1:0] w_period;
    logic             w_tick;
    logic [LED_W-1:0] w_seed;
    logic [LED_W-1:0] w_step_led;
    dir_e             w_step_dir;

    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != LED_ZERO) && ((v & (v - LED_ONE)) == LED_ZERO);
    endfunction

    // Bar-fill values are a contiguous run of ones starting at bit 0.
    function automatic logic is_fill(input logic [LED_W-1:0] v);
        return (v != LED_ZERO) && (((v + LED_ONE) & v) == LED_ZERO);
    endfunction

    // Reset synchroniser: asynchronous assertion, release aligned to the clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .i_clk   (i_clk),
        .i_rst_n (w_rst_n),
        .i_btn   (i_btn_start),
        .o_pulse (w_start_p)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .i_clk   (i_clk),
        .i_rst_n (w_rst_n),
        .i_btn   (i_btn_stop),
        .o_pulse (w_stop_p)
    );

    // >= rather than == lets a mid-period speed-up step immediately.
    assign w_period = TICK_DIV_C >> i_speed;
    assign w_tick   = (r_cnt >= (w_period - CNT_ONE));
    assign w_seed   = LED_W'(seed(i_mode, LED_W));

    // Next pattern for the current mode; unreachable values fall back to the seed.
    always_comb begin
        w_step_led = w_seed;
        w_step_dir = DIR_LEFT;
        case (r_mode_q)
            MODE_ROTL: begin
                if (is_onehot(r_led)) begin
                    w_step_led = {r_led[LED_W-2:0], r_led[LED_W-1]};
                end else begin
                    w_step_led = w_seed;
                end
            end
            MODE_ROTR: begin
                if (is_onehot(r_led)) begin
                    w_step_led = {r_led[0], r_led[LED_W-1:1]};
                end else begin
                    w_step_led = w_seed;
                end
            end
            MODE_PING: begin
                if (!is_onehot(r_led)) begin
                    w_step_led = w_seed;
                    w_step_dir = DIR_LEFT;
                end else if (((r_dir == DIR_LEFT) && r_led[LED_W-1]) ||
                             ((r_dir == DIR_RIGHT) && !r_led[0])) begin
                    w_step_led = r_led >> 1;
                    w_step_dir = DIR_RIGHT;
                end else begin
                    w_step_led = r_led << 1;
                    w_step_dir = DIR_LEFT;
                end
            end
            MODE_FILL: begin
                if (!is_fill(r_led)) begin
                    w_step_led = w_seed;
                end else if (&r_led) begin
                    w_step_led = LED_ONE;
                end else begin
                    w_step_led = {r_led[LED_W-2:0], 1'b1};
                end
            end
            default: begin
                w_step_led = w_seed;
            end
        endcase
    end

    // State transitions and datapath next values; stop wins over start.
    always_comb begin
        w_state_nxt  = r_state;
        w_led_nxt    = r_led;
        w_cnt_nxt    = r_cnt;
        w_dir_nxt    = r_dir;
        w_mode_q_nxt = r_mode_q;
        case (r_state)
            IDLE: begin
                w_mode_q_nxt = i_mode;
                w_led_nxt    = LED_ZERO;
                w_cnt_nxt    = CNT_ZERO;
                w_dir_nxt    = DIR_LEFT;
                if (w_stop_p) begin
                    w_state_nxt = IDLE;
                end else if (w_start_p) begin
                    w_state_nxt = RUN;
                    w_led_nxt   = w_seed;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_stop_p) begin
                    w_state_nxt = HOLD;
                end else if (i_mode != r_mode_q) begin
                    w_mode_q_nxt = i_mode;
                    w_led_nxt    = w_seed;
                    w_cnt_nxt    = CNT_ZERO;
                    w_dir_nxt    = DIR_LEFT;
                end else if (w_tick) begin
                    w_cnt_nxt = CNT_ZERO;
                    w_led_nxt = w_step_led;
                    w_dir_nxt = w_step_dir;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HOLD: begin
                // mode_q is left alone here so a mode change reseeds on resume.
                if (w_stop_p) begin
                    w_state_nxt = IDLE;
                    w_led_nxt   = LED_ZERO;
                    w_cnt_nxt   = CNT_ZERO;
                    w_dir_nxt   = DIR_LEFT;
                end else if (w_start_p) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_led_nxt   = LED_ZERO;
                w_cnt_nxt   = CNT_ZERO;
                w_dir_nxt   = DIR_LEFT;
            end
        endcase
    end

    // State register and registered running flag.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    // Pattern, prescaler, direction and mode-tracking registers.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_led    <= LED_ZERO;
            r_cnt    <= CNT_ZERO;
            r_dir    <= DIR_LEFT;
            r_mode_q <= 2'd0;
        end else begin
            r_led    <= w_led_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
            r_mode_q <= w_mode_q_nxt;
        end
    end

    assign o_led     = r_led;
    assign o_running = r_running;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer (LED_W=8, TICK_DIV=8).
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start;
    logic       btn_stop;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [7:0] led;
    logic       running;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] rotl_tbl [0:7] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] ping_tbl [0:14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_tbl [0:7] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .LED_W       (8),
        .TICK_DIV    (8),
        .CNT_W       (32),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_start (btn_start),
        .i_btn_stop  (btn_stop),
        .i_mode      (mode),
        .i_speed     (speed),
        .o_led       (led),
        .o_running   (running)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; mode = 2'd0; speed = 2'd0;
        cyc(3);
        chk("reset_led", {24'd0, led}, 32'h00);
        chk("reset_running", {31'd0, running}, 32'd0);
        rst_n = 1'b1;
        cyc(5);
        chk("idle_no_motion", {24'd0, led}, 32'h00);

        // Rotate-left, speed 0, including button-to-LED latency.
        btn_start = 1'b1;
        cyc(3);
        chk("start_latency_early", {24'd0, led}, 32'h00);
        cyc(1);
        btn_start = 1'b0;
        chk("start_seed", {24'd0, led}, 32'h01);
        chk("start_running", {31'd0, running}, 32'd1);
        cyc(7);
        chk("rotl_hold_period", {24'd0, led}, 32'h01);
        cyc(1);
        chk("rotl_step0", {24'd0, led}, {24'd0, rotl_tbl[0]});
        for (int i = 1; i < 8; i++) begin
            cyc(8);
            chk("rotl_step", {24'd0, led}, {24'd0, rotl_tbl[i]});
        end

        // Ping-pong.
        mode = 2'd2;
        cyc(1);
        chk("ping_seed", {24'd0, led}, 32'h01);
        for (int i = 0; i < 15; i++) begin
            cyc(8);
            chk("ping_step", {24'd0, led}, {24'd0, ping_tbl[i]});
        end

        // Bar-fill at speed 2, then a mid-period speed increase.
        mode = 2'd3; speed = 2'd2;
        cyc(1);
        chk("fill_seed", {24'd0, led}, 32'h01);
        for (int i = 0; i < 8; i++) begin
            cyc(2);
            chk("fill_step", {24'd0, led}, {24'd0, fill_tbl[i]});
        end
        speed = 2'd0;
        cyc(5);
        chk("speedup_before", {24'd0, led}, 32'h01);
        speed = 2'd3;
        cyc(1);
        chk("speedup_step", {24'd0, led}, 32'h03);
        cyc(1);
        chk("speed3_step", {24'd0, led}, 32'h07);

        // Pause at 0x10, resume, then stop twice to clear.
        mode = 2'd0; speed = 2'd0;
        cyc(1);
        chk("reseed_rotl", {24'd0, led}, 32'h01);
        cyc(32);
        chk("reach_10", {24'd0, led}, 32'h10);
        btn_stop = 1'b1;
        cyc(4);
        btn_stop = 1'b0;
        chk("hold_running", {31'd0, running}, 32'd0);
        cyc(50);
        chk("hold_frozen", {24'd0, led}, 32'h10);
        btn_start = 1'b1;
        cyc(4);
        btn_start = 1'b0;
        chk("resume_running", {31'd0, running}, 32'd1);
        cyc(4);
        chk("resume_cnt_kept", {24'd0, led}, 32'h10);
        cyc(1);
        chk("resume_step", {24'd0, led}, 32'h20);
        btn_stop = 1'b1;
        cyc(4);
        btn_stop = 1'b0;
        cyc(4);
        chk("stop1_led", {24'd0, led}, 32'h20);
        btn_stop = 1'b1;
        cyc(4);
        btn_stop = 1'b0;
        cyc(4);
        chk("stop2_clear", {24'd0, led}, 32'h00);
        chk("stop2_running", {31'd0, running}, 32'd0);

        // Simultaneous start and stop from IDLE: stop wins.
        btn_start = 1'b1; btn_stop = 1'b1;
        cyc(4);
        btn_start = 1'b0; btn_stop = 1'b0;
        cyc(4);
        chk("both_led", {24'd0, led}, 32'h00);
        chk("both_running", {31'd0, running}, 32'd0);

        // Held start gives one pulse: a stop while it is held must stick.
        btn_start = 1'b1;
        cyc(4);
        chk("held_start_led", {24'd0, led}, 32'h01);
        cyc(36);
        btn_stop = 1'b1;
        cyc(4);
        btn_stop = 1'b0;
        chk("held_stop_running", {31'd0, running}, 32'd0);
        cyc(56);
        chk("held_no_restart", {31'd0, running}, 32'd0);
        chk("held_frozen_led", {24'd0, led}, 32'h10);
        btn_start = 1'b0;
        btn_stop = 1'b1;
        cyc(4);
        btn_stop = 1'b0;
        cyc(4);
        chk("held_clear", {24'd0, led}, 32'h00);

        // Mode 0 -> 1 mid-RUN reseeds to the MSB.
        btn_start = 1'b1;
        cyc(4);
        btn_start = 1'b0;
        chk("mc_start", {24'd0, led}, 32'h01);
        cyc(3);
        mode = 2'd1;
        cyc(1);
        chk("mc_seed", {24'd0, led}, 32'h80);
        cyc(7);
        chk("mc_hold", {24'd0, led}, 32'h80);
        cyc(1);
        chk("mc_step", {24'd0, led}, 32'h40);

        // Asynchronous reset mid-RUN.
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", {24'd0, led}, 32'h00);
        chk("async_rst_running", {31'd0, running}, 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        chk("post_rst_led", {24'd0, led}, 32'h00);
        chk("post_rst_running", {31'd0, running}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
